// File: rtl/sr_flag_arbiter.sv
// Two-requester set/reset flag bank: round-robin arbitration, one command per
// IDLE -> EXEC -> DONE pass, with a registered ack/err pulse on the way out of DONE.
module sr_flag_arbiter #(
    parameter int NFLAGS = 8,
    parameter int IW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              s_a,
    input  logic              r_a,
    input  logic [IW-1:0]     idx_a,
    input  logic              req_b,
    input  logic              s_b,
    input  logic              r_b,
    input  logic [IW-1:0]     idx_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic              err,
    output logic              busy,
    output logic [NFLAGS-1:0] q
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [NFLAGS-1:0] q_q, q_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic              err_q, err_d;
    logic              last_grant_q, last_grant_d;  // 0 = A, 1 = B
    logic              win_q, win_d;
    logic              s_q, s_d;
    logic              r_q, r_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              win;

    always_comb begin
        state_d      = state_q;
        q_d          = q_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        err_d        = 1'b0;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        s_d          = s_q;
        r_d          = r_q;
        idx_d        = idx_q;
        // Under contention the requester that was not served last gets the grant.
        win          = (req_a && req_b) ? ~last_grant_q : req_b;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    win_d   = win;
                    s_d     = win ? s_b   : s_a;
                    r_d     = win ? r_b   : r_a;
                    idx_d   = win ? idx_b : idx_a;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (s_q && !r_q) begin
                    q_d[idx_q] = 1'b1;
                end else if (!s_q && r_q) begin
                    q_d[idx_q] = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                ack_a_d      = ~win_q;
                ack_b_d      = win_q;
                err_d        = s_q & r_q;
                last_grant_d = win_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            q_q          <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
        end
    end

    // Latched command payload is only consumed after IDLE has loaded it.
    always_ff @(posedge clk) begin
        s_q   <= s_d;
        r_q   <= r_d;
        idx_q <= idx_d;
    end

    assign ack_a = ack_a_q;
    assign ack_b = ack_b_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);
    assign q     = q_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Table-driven bench for sr_flag_arbiter with a scoreboard of expected completions
// and a hand-written mid-EXEC reset sequence.
module tb_sr_flag_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_a = 1'b0, s_a = 1'b0, r_a = 1'b0;
    logic [2:0] idx_a = '0;
    logic       req_b = 1'b0, s_b = 1'b0, r_b = 1'b0;
    logic [2:0] idx_b = '0;
    logic       ack_a, ack_b, err, busy;
    logic [7:0] q;

    int n_chk  = 0;
    int n_fail = 0;

    sr_flag_arbiter #(.NFLAGS(8), .IW(3)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .s_a(s_a), .r_a(r_a), .idx_a(idx_a),
        .req_b(req_b), .s_b(s_b), .r_b(r_b), .idx_b(idx_b),
        .ack_a(ack_a), .ack_b(ack_b), .err(err), .busy(busy), .q(q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ra, sa, rra;
        logic [2:0] ia;
        logic       rb, sb, rrb;
        logic [2:0] ib;
        logic       first_b;   // B expected to complete first
        logic       scr;       // disturb the winner's inputs after acceptance
        logic [7:0] q1;
        logic       e1;
        logic [7:0] q2;
        logic       e2;
    } vec_t;

    typedef struct {
        logic       ack_a, ack_b, err;
        logic [7:0] q;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[12];

    function automatic vec_t mk(logic ra, logic sa, logic rra, logic [2:0] ia,
                                logic rb, logic sb, logic rrb, logic [2:0] ib,
                                logic fb, logic scr, logic [7:0] q1, logic e1,
                                logic [7:0] q2, logic e2);
        vec_t v;
        v.ra = ra; v.sa = sa; v.rra = rra; v.ia = ia;
        v.rb = rb; v.sb = sb; v.rrb = rrb; v.ib = ib;
        v.first_b = fb; v.scr = scr;
        v.q1 = q1; v.e1 = e1; v.q2 = q2; v.e2 = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t       e;
        int         cyc;
        int         pending;
        logic [7:0] q_prev;
        @(negedge clk);
        req_a = v.ra; s_a = v.sa; r_a = v.rra; idx_a = v.ia;
        req_b = v.rb; s_b = v.sb; r_b = v.rrb; idx_b = v.ib;
        pending = int'(v.ra) + int'(v.rb);
        e.ack_a = ~v.first_b; e.ack_b = v.first_b; e.err = v.e1; e.q = v.q1; e.lat = 3;
        sbq.push_back(e);
        if (pending == 2) begin
            e.ack_a = v.first_b; e.ack_b = ~v.first_b; e.err = v.e2; e.q = v.q2; e.lat = 6;
            sbq.push_back(e);
        end
        q_prev = q;
        cyc    = 0;
        while (pending > 0 && cyc < 15) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({tag, "_busy"}, busy, 1);
                if (v.scr) begin
                    if (v.first_b) begin s_b = ~s_b; r_b = ~r_b; idx_b = ~idx_b; end
                    else begin s_a = ~s_a; r_a = ~r_a; idx_a = ~idx_a; end
                end
            end
            if (ack_a || ack_b) begin
                check({tag, "_ack_excl"}, ack_a & ack_b, 0);
                if (sbq.size() == 0) begin
                    check({tag, "_unexpected_ack"}, 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check({tag, "_ack_a"}, ack_a, e.ack_a);
                    check({tag, "_ack_b"}, ack_b, e.ack_b);
                    check({tag, "_err"}, err, e.err);
                    check({tag, "_q"}, q, e.q);
                    check({tag, "_q_before_ack"}, q_prev, e.q);
                    check({tag, "_latency"}, cyc, e.lat);
                end
                if (ack_a) req_a = 1'b0;
                if (ack_b) req_b = 1'b0;
                pending--;
            end
            q_prev = q;
        end
        if (pending > 0) begin
            check({tag, "_timeout"}, pending, 0);
            sbq.delete();
        end
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        check({tag, "_ack_pulse"}, {ack_a, ack_b}, 0);
    endtask

    initial begin
        logic seen_ack;
        tbl[0]  = mk(1,1,0,3'd5, 0,0,0,3'd0, 0,0, 8'h20,0, 8'h00,0);
        tbl[1]  = mk(0,0,0,3'd0, 1,0,1,3'd5, 1,1, 8'h00,0, 8'h00,0);
        tbl[2]  = mk(1,1,0,3'd1, 1,1,0,3'd2, 0,0, 8'h02,0, 8'h06,0);
        tbl[3]  = mk(1,1,0,3'd3, 1,1,0,3'd4, 0,1, 8'h0E,0, 8'h1E,0);
        tbl[4]  = mk(1,1,1,3'd3, 0,0,0,3'd0, 0,0, 8'h1E,1, 8'h00,0);
        tbl[5]  = mk(1,0,0,3'd6, 0,0,0,3'd0, 0,0, 8'h1E,0, 8'h00,0);
        tbl[6]  = mk(1,1,0,3'd6, 1,1,0,3'd7, 1,0, 8'h9E,0, 8'hDE,0);
        tbl[7]  = mk(0,0,0,3'd0, 1,1,0,3'd0, 1,0, 8'hDF,0, 8'h00,0);
        tbl[8]  = mk(1,0,1,3'd4, 0,0,0,3'd0, 0,0, 8'hCF,0, 8'h00,0);
        tbl[9]  = mk(1,1,0,3'd4, 0,0,0,3'd0, 0,0, 8'hDF,0, 8'h00,0);
        tbl[10] = mk(1,1,0,3'd5, 0,0,0,3'd0, 0,0, 8'hFF,0, 8'h00,0);
        tbl[11] = mk(1,1,0,3'd7, 1,1,0,3'd1, 0,0, 8'h80,0, 8'h82,0);

        repeat (2) @(negedge clk);
        check("rst_q", q, 0);
        check("rst_acks", {ack_a, ack_b}, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // Clear command aborted by reset while in EXEC.
        @(negedge clk);
        req_a = 1'b1; s_a = 1'b0; r_a = 1'b1; idx_a = 3'd2;
        @(negedge clk);
        check("abort_busy_exec", busy, 1);
        rst = 1'b0;
        #1;
        check("abort_q", q, 0);
        check("abort_busy", busy, 0);
        check("abort_acks", {ack_a, ack_b, err}, 0);
        req_a = 1'b0;
        seen_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack_a || ack_b) seen_ack = 1'b1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack_a || ack_b) seen_ack = 1'b1;
        end
        check("abort_no_ack", seen_ack, 0);
        check("abort_q_after", q, 0);

        run_vec(tbl[11], "v11");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_flag_arbiter.md
SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

Interface
REQ-001 Parameter NFLAGS, default 8, number of SR flags in the shared bank; SHALL be a power of two, 2..32.
REQ-002 Parameter IW, default 3, flag index width; SHALL equal log2(NFLAGS).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-low.
REQ-005 req_a  input  1  requester A request; held high until ack_a.
REQ-006 s_a, r_a  input  1 each  requester A set/reset command, sampled with req_a.
REQ-007 idx_a  input  IW  requester A target flag index.
REQ-008 req_b, s_b, r_b, idx_b  input  1/1/1/IW  requester B equivalents.
REQ-009 ack_a, ack_b  output  1 each  one-cycle completion pulse to the served requester.
REQ-010 err  output  1  one-cycle pulse, coincident with ack, when the served command was s=1,r=1.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 q  output  NFLAGS  registered flag bank contents.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-014 IDLE: if neither req is high, the FSM SHALL remain in IDLE; otherwise it SHALL latch the winner's s, r, idx and winner identity, then go to EXEC.
REQ-015 Arbitration when only one req is high: that requester SHALL win.
REQ-016 Arbitration when both reqs are high: the requester not granted most recently SHALL win (round-robin, pointer last_grant).
REQ-017 EXEC: the FSM SHALL apply the latched command to q[idx] and go to DONE.
REQ-018 Command encoding: s=1,r=0 sets q[idx]; s=0,r=1 clears q[idx]; s=0,r=0 leaves q unchanged (no-op, still acknowledged); s=1,r=1 leaves q unchanged and flags an error.
REQ-019 Only bit idx of q SHALL change in EXEC; all other bits SHALL hold.
REQ-020 DONE: the FSM SHALL pulse ack for the winner only, pulse err if the latched command was s=1,r=1, update last_grant to the winner, and return to IDLE.
REQ-021 Latency: ack SHALL assert exactly 2 cycles after the IDLE edge that accepted the request; q SHALL be updated 1 cycle before ack.
REQ-022 Throughput: at most one command SHALL complete per 3 cycles.
REQ-023 A requester SHALL drop req in the cycle after its ack; a req still high in IDLE SHALL be treated as a new request.
REQ-024 Changes to the losing requester's s, r, idx while it waits SHALL be sampled only when it wins.
REQ-025 Changes to req, s, r, idx in EXEC or DONE SHALL NOT affect the in-flight command.
REQ-026 ack_a and ack_b SHALL never be high in the same cycle.

Reset
REQ-027 While rst is low, the design SHALL immediately force: state=IDLE, q=0, ack_a=0, ack_b=0, err=0, busy=0, and last_grant=B, so A wins the first contention.
REQ-028 Reset asserted in EXEC or DONE SHALL abort the command; no ack SHALL be issued, and q SHALL read 0 after reset.
REQ-029 After rst rises, the first request SHALL be accepted on the first rising clk edge at which it is high.

Verification
REQ-030 Scenario 1: req_a with s=1, r=0, idx=5 from reset -> q=0x20 one cycle before ack_a; ack_a is a single pulse 2 cycles after acceptance; err=0.
REQ-031 Scenario 2: set idx 5 as in Scenario 1, then req_b with s=0, r=1, idx=5 -> q=0x00; ack_b pulses; ack_a stays 0.
REQ-032 Scenario 3: after reset, req_a (set idx 1) and req_b (set idx 2) raised together and held until ack -> A served first (q=0x02, ack_a), then B (q=0x06, ack_b); the next simultaneous pair is served A then B again, because last_grant=B after B's service.
REQ-033 Scenario 4: req_a with s=1, r=1, idx=3 -> q unchanged; err and ack_a pulse together.
REQ-034 Scenario 5: req_a with s=0, r=0 -> ack_a pulses; q unchanged; err=0.
REQ-035 Scenario 6: q=0xFF, then rst driven low mid-EXEC of a clear command -> q=0x00 immediately; no ack; busy=0; after release, a set on idx 7 yields q=0x80.
